// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single memory port between the CPU and the debug monitor.
// Optional macro MON_PRIORITY_EN: monitor always wins a tie (fixed priority) instead of round-robin.
module mem_arbiter #(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_wait,
    input  logic          mon_req,
    input  logic          mon_we,
    input  logic [AW-1:0] mon_addr,
    input  logic [DW-1:0] mon_wdata,
    output logic          mon_ack,
    output logic [DW-1:0] mon_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    owner
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;

    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_MON  = 2'b10;
    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

    logic [1:0] state;
    logic [1:0] lat_cnt;
    logic       acc_we;
    logic       grant_cpu;
    logic       grant_mon;
`ifndef MON_PRIORITY_EN
    logic       last_winner_mon;
`endif

    assign cpu_wait = cpu_req & ~cpu_ack;

    always_comb begin
        grant_cpu = 1'b0;
        grant_mon = 1'b0;
        if (cpu_req && mon_req) begin
`ifdef MON_PRIORITY_EN
            grant_mon = 1'b1;
`else
            grant_cpu = last_winner_mon;
            grant_mon = ~last_winner_mon;
`endif
        end else begin
            grant_cpu = cpu_req;
            grant_mon = mon_req;
        end
    end

    // mem_addr/mem_wdata double as the latched request; they are only loaded on a grant
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            lat_cnt   <= '0;
            acc_we    <= 1'b0;
            owner     <= '0;
            cpu_ack   <= 1'b0;
            mon_ack   <= 1'b0;
            cpu_rdata <= '0;
            mon_rdata <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
`ifndef MON_PRIORITY_EN
            last_winner_mon <= 1'b1;
`endif
        end else begin
            cpu_ack <= 1'b0;
            mon_ack <= 1'b0;
            mem_we  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_cpu || grant_mon) begin
                        owner     <= grant_mon ? OWN_MON : OWN_CPU;
                        acc_we    <= grant_mon ? mon_we : cpu_we;
                        mem_we    <= grant_mon ? mon_we : cpu_we;
                        mem_addr  <= grant_mon ? mon_addr : cpu_addr;
                        mem_wdata <= grant_mon ? mon_wdata : cpu_wdata;
                        lat_cnt   <= LAT_LOAD;
`ifndef MON_PRIORITY_EN
                        last_winner_mon <= grant_mon;
`endif
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (acc_we || lat_cnt == 2'd0) begin
                        if (!acc_we) begin
                            if (owner[1]) mon_rdata <= mem_rdata;
                            else          cpu_rdata <= mem_rdata;
                        end
                        cpu_ack <= owner[0];
                        mon_ack <= owner[1];
                        state   <= ST_ACK;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                ST_ACK: begin
                    owner <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    owner <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model of grants, latencies and memory.
// Honours MON_PRIORITY_EN in the model when the macro is defined for the build.
module tb_mem_arbiter;

    localparam int LAT = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we, mon_req, mon_we;
    logic [7:0] cpu_addr, cpu_wdata, mon_addr, mon_wdata;
    logic       cpu_ack, mon_ack, cpu_wait, mem_we;
    logic [7:0] cpu_rdata, mon_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0] owner;

    always #5 clock = ~clock;

    mem_arbiter #(.AW(8), .DW(8), .RD_LAT(LAT)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
        .mon_req(mon_req), .mon_we(mon_we), .mon_addr(mon_addr), .mon_wdata(mon_wdata),
        .mon_ack(mon_ack), .mon_rdata(mon_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .owner(owner)
    );

    // Memory: data is only correct once the address has been presented for LAT cycles
    logic [7:0]  mem_array [256];
    logic [7:0]  seen_addr = 8'h00;
    int unsigned seen_age  = 0;
    int unsigned present_cycles;
    logic        poke_en = 1'b0;
    logic [7:0]  poke_addr = 8'h00, poke_data = 8'h00;

    always_comb present_cycles = (mem_addr == seen_addr) ? seen_age + 1 : 1;
    always_comb mem_rdata = (present_cycles >= LAT) ? mem_array[mem_addr] : ~mem_array[mem_addr];

    always @(posedge clock) begin
        if (poke_en) mem_array[poke_addr] = poke_data;
        if (mem_we)  mem_array[mem_addr]  = mem_wdata;
        seen_addr <= mem_addr;
        seen_age  <= (present_cycles > 8) ? 8 : present_cycles;
    end

    // Reference model state
    logic [7:0]  ref_mem [256];
    int unsigned total_cnt = 0, bad_cnt = 0, cyc = 0;
    bit          busy = 0, last_mon = 1, t_we = 0;
    int unsigned g = 0, acc_len = 1;
    int          who = 0;
    logic [7:0]  t_addr = 0, t_wdata = 0, t_rval = 0, t_old = 0;
    logic [7:0]  exp_rdata [2];
    bit          req_lvl [2], outstanding [2], want [2], w_we [2], d_we [2];
    logic [7:0]  w_addr [2], w_wdata [2], d_addr [2], d_wdata [2];
    int unsigned violate_pct = 0;
    bit          scramble = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic apply_inputs();
        cpu_req = req_lvl[0]; cpu_we = d_we[0]; cpu_addr = d_addr[0]; cpu_wdata = d_wdata[0];
        mon_req = req_lvl[1]; mon_we = d_we[1]; mon_addr = d_addr[1]; mon_wdata = d_wdata[1];
    endtask

    // Called at a negedge: check this cycle, drive the next inputs, cross one posedge, update the model
    task automatic tick();
        bit         acc, ackc;
        logic [1:0] eown;
        int         win;
        acc  = busy && cyc >= g && cyc < g + acc_len;
        ackc = busy && cyc == g + acc_len;
        eown = !busy ? 2'b00 : (who == 1 ? 2'b10 : 2'b01);
        check_eq("owner", 32'(owner), 32'(eown));
        check_eq("mem_we", 32'(mem_we), 32'(acc && t_we));
        check_eq("cpu_ack", 32'(cpu_ack), 32'(ackc && who == 0));
        check_eq("mon_ack", 32'(mon_ack), 32'(ackc && who == 1));
        check_eq("cpu_rdata", 32'(cpu_rdata), 32'(exp_rdata[0]));
        check_eq("mon_rdata", 32'(mon_rdata), 32'(exp_rdata[1]));
        check_eq("cpu_wait", 32'(cpu_wait), 32'(req_lvl[0] && !(ackc && who == 0)));
        if (acc) begin
            check_eq("mem_addr", 32'(mem_addr), 32'(t_addr));
            check_eq("mem_wdata", 32'(mem_wdata), 32'(t_wdata));
        end

        for (int r = 0; r < 2; r++) begin
            if (ackc && who == r) begin
                req_lvl[r] = 0;
                outstanding[r] = 0;
            end else if (outstanding[r]) begin
                if (acc && who == r) begin
                    if ($urandom_range(0, 99) < violate_pct) req_lvl[r] = 0;
                    if (scramble) begin
                        d_we[r] = 1'($urandom); d_addr[r] = 8'($urandom); d_wdata[r] = 8'($urandom);
                    end
                end
            end else if (want[r]) begin
                req_lvl[r] = 1; outstanding[r] = 1; want[r] = 0;
                d_we[r] = w_we[r]; d_addr[r] = w_addr[r]; d_wdata[r] = w_wdata[r];
            end
        end
        apply_inputs();

        @(posedge clock);
        cyc++;
        if (busy) begin
            if (cyc == g + acc_len && !t_we) exp_rdata[who] = t_rval;
            if (cyc == g + acc_len + 1) busy = 0;
        end else if (req_lvl[0] || req_lvl[1]) begin
            if (req_lvl[0] && req_lvl[1]) begin
`ifdef MON_PRIORITY_EN
                win = 1;
`else
                win = last_mon ? 0 : 1;
`endif
            end else begin
                win = req_lvl[1] ? 1 : 0;
            end
            last_mon = (win == 1);
            busy = 1; g = cyc; who = win;
            t_we = d_we[win]; t_addr = d_addr[win]; t_wdata = d_wdata[win];
            acc_len = t_we ? 1 : LAT;
            t_old = ref_mem[t_addr];
            if (t_we) ref_mem[t_addr] = t_wdata;
            else      t_rval = ref_mem[t_addr];
        end
        @(negedge clock);
        poke_en = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        ref_mem[a] = d;
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        tick();
    endtask

    task automatic issue(input int r, input bit we, input logic [7:0] a, input logic [7:0] d);
        want[r] = 1; w_we[r] = we; w_addr[r] = a; w_wdata[r] = d;
    endtask

    task automatic reset_mid_write();
        issue(0, 1, 8'h30, 8'h5A);
        for (int i = 0; i < 20 && !(busy && who == 0 && t_we && cyc == g); i++) tick();
        check_eq("wr_strobe_pre_rst", 32'(mem_we), 32'(1));
        #1 reset = 1'b1;
        #1;
        check_eq("rst_mem_we", 32'(mem_we), 32'(0));
        check_eq("rst_owner", 32'(owner), 32'(0));
        check_eq("rst_cpu_ack", 32'(cpu_ack), 32'(0));
        check_eq("rst_mem_addr", 32'(mem_addr), 32'(0));
        // The aborted write never reaches memory, so the model drops it too
        ref_mem[t_addr] = t_old;
        busy = 0; last_mon = 1; exp_rdata[0] = 0; exp_rdata[1] = 0;
        for (int r = 0; r < 2; r++) begin
            req_lvl[r] = 0; outstanding[r] = 0; want[r] = 0;
        end
        apply_inputs();
        @(posedge clock);
        cyc++;
        @(negedge clock);
        check_eq("rst_no_ack", 32'(cpu_ack), 32'(0));
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        reset = 1'b1;
        for (int r = 0; r < 2; r++) begin
            req_lvl[r] = 0; outstanding[r] = 0; want[r] = 0; w_we[r] = 0; d_we[r] = 0;
            w_addr[r] = 0; w_wdata[r] = 0; d_addr[r] = 0; d_wdata[r] = 0; exp_rdata[r] = 0;
        end
        apply_inputs();
        for (int i = 0; i < 256; i++) begin
            @(negedge clock);
            v = 8'($urandom);
            ref_mem[i] = v;
            poke_en = 1'b1; poke_addr = 8'(i); poke_data = v;
        end
        @(negedge clock);
        poke_en = 1'b0;
        check_eq("reset_owner", 32'(owner), 32'(0));
        check_eq("reset_mem_we", 32'(mem_we), 32'(0));
        check_eq("reset_mem_addr", 32'(mem_addr), 32'(0));
        check_eq("reset_mem_wdata", 32'(mem_wdata), 32'(0));
        check_eq("reset_acks", 32'({cpu_ack, mon_ack}), 32'(0));
        check_eq("reset_rdata", 32'({cpu_rdata, mon_rdata}), 32'(0));
        reset = 1'b0;

        poke(8'h10, 8'h3C);
        issue(0, 0, 8'h10, 8'h00);
        run(8);
        issue(1, 1, 8'h20, 8'hA5);
        run(6);
        issue(0, 0, 8'h20, 8'h00);
        run(8);
        poke(8'h7F, 8'h11);
        issue(1, 0, 8'h7F, 8'h00);
        run(8);

        reset_mid_write();

        // Both requesters raise together after reset and re-request after every ack
        for (int i = 0; i < 30; i++) begin
            if (!want[0]) issue(0, 0, 8'h40, 8'h00);
            if (!want[1]) issue(1, 1, 8'h41, 8'(i));
            tick();
        end
        want[0] = 0; want[1] = 0;
        run(LAT + 4);

        violate_pct = 5;
        scramble    = 1;
        for (int i = 0; i < 3000; i++) begin
            for (int r = 0; r < 2; r++)
                if (!want[r] && $urandom_range(0, 99) < 35)
                    issue(r, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
            tick();
        end
        want[0] = 0; want[1] = 0;
        violate_pct = 0;
        run(2 * LAT + 6);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 8-bit program/data memory port between the CPU (the datapath/controller memory path) and the debug monitor.
- Each requester uses a req/ack handshake. The arbiter serialises the two, drives the memory port, and returns read data.
- Round-robin arbitration, so the monitor can inspect or patch memory while a program runs without starving the CPU.
- Also produces a CPU wait signal that feeds the cycle counter pause.

Parameters:
AW, 8, address width
DW, 8, data width
RD_LAT, 1, memory read latency in cycles (legal 1..4): mem_rdata is valid RD_LAT cycles after mem_addr is first presented

Ports:
clock      in   1   system clock; all state changes on posedge
reset      in   1   asynchronous, active-high reset
cpu_req    in   1   CPU access request; held high until ack
cpu_we     in   1   1 = write, 0 = read; stable while cpu_req is high
cpu_addr   in   AW  CPU address
cpu_wdata  in   DW  CPU write data
cpu_ack    out  1   one-cycle completion pulse
cpu_rdata  out  DW  read data; valid while cpu_ack is high, held afterwards
cpu_wait   out  1   cpu_req & ~cpu_ack (combinational); drives pause_cc
mon_req    in   1   monitor request (same rules as cpu_req)
mon_we     in   1   monitor write enable
mon_addr   in   AW  monitor address
mon_wdata  in   DW  monitor write data
mon_ack    out  1   monitor completion pulse
mon_rdata  out  DW  monitor read data
mem_addr   out  AW  memory address
mem_wdata  out  DW  memory write data
mem_we     out  1   memory write strobe
mem_rdata  in   DW  memory read data
owner      out  2   one-hot current owner {1:MON, 0:CPU}; 00 = idle

Behaviour:
- Reset values (asynchronous, immediate):
  - state = IDLE
  - all acks 0; rdata regs 0; mem_addr/mem_wdata 0; mem_we 0; owner 00
  - last_winner = MON, so the CPU wins the first tie
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - If exactly one req is high, that requester wins.
  - If both are high, the requester that is not last_winner wins.
  - On the winning edge, latch the winner's we/addr/wdata into internal regs, set owner, update last_winner, and go to ACCESS.
  - If no req is high, stay in IDLE; owner = 00.
- ACCESS:
  - mem_addr and mem_wdata are driven from the latched regs for the whole state.
  - Write: exactly 1 cycle with mem_we = 1, then go to ACK.
  - Read: mem_we = 0; stay RD_LAT cycles (down-counter loaded with RD_LAT-1). At the edge ending the last ACCESS cycle, capture mem_rdata into the owner's rdata reg, then go to ACK.
- ACK:
  - Owner's ack = 1 for exactly one cycle; mem_we = 0.
  - Then go to IDLE with owner = 00.
- Latency from the req-sampling edge to ack high:
  - write: 2 cycles
  - read: RD_LAT+1 cycles
- Handshake rules:
  - A requester deasserts req at the edge where it samples ack = 1, so req is low in the following IDLE cycle.
  - Back-to-back accesses from one requester therefore take at least one IDLE cycle between them.
- The non-owner's req is ignored outside IDLE. It stays pending, and its ack stays 0.
- Request inputs changing during ACCESS have no effect, because the access uses the latched regs.
- If req drops mid-transaction (protocol violation), the access still completes and ack is still pulsed.
- rdata of the non-owner is never modified. A write does not change the owner's rdata.
- mem_we is never high outside ACCESS, and never high for a read.
- Reset asserted mid-ACCESS:
  - mem_we drops immediately; no ack is issued; the FSM returns to IDLE.
  - Any partially started write is the memory's concern. Requesters must re-issue after reset.
- Counter width: 2 bits (supports RD_LAT up to 4).

Optional Feature:
MON_PRIORITY_EN
- Defined: fixed priority. The monitor always wins when both reqs are high in IDLE; last_winner is unused.
  - Acceptable only because monitor traffic is sparse and user-driven.
  - The CPU can be starved only while mon_req is re-asserted every IDLE cycle.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Reset, then CPU read of addr 0x10 (memory holds 0x3C), RD_LAT = 1 -> cpu_ack high 2 cycles after the req edge; cpu_rdata = 0x3C; mon_ack stays 0; mem_we never high.
- Monitor write 0xA5 to 0x20 -> mem_we high for exactly 1 cycle with mem_addr = 0x20 and mem_wdata = 0xA5; mon_ack 1 cycle later; a subsequent CPU read of 0x20 returns 0xA5.
- Both reqs raised on the same edge after reset, each re-requesting after its ack -> grant order CPU, MON, CPU, MON; owner one-hot in each transaction; cpu_wait high while the CPU is pending.
- RD_LAT = 3, monitor read of 0x7F (= 0x11) -> mem_addr held 0x7F for 3 ACCESS cycles; mon_ack 4 cycles after the req edge; mon_rdata = 0x11; cpu_rdata unchanged.
- Reset asserted in the middle of a CPU write's ACCESS cycle -> mem_we = 0 immediately; no cpu_ack; state IDLE; the next req is served normally.
- With MON_PRIORITY_EN, both reqs held continuously -> the monitor wins every arbitration; the CPU is granted on the first IDLE cycle in which mon_req = 0.
